// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two requesters, the response consumer and
// alu_arbiter.
//   req0_* / req1_* : valid, opcode (00 ADD, 01 SUB, 10 NAND, 11 XOR), a, b.
//                     ready comes back from the arbiter.
//   rsp_*           : valid, id, data and err go to the consumer.
//                     ready comes back from the consumer.
// master : requester/consumer side.  slave : arbiter side.
interface alu_arbiter_if #(
  parameter int DATA_W = 4
);
  logic              req0_valid;
  logic [1:0]        req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              req0_ready;

  logic              req1_valid;
  logic [1:0]        req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic              req1_ready;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_err,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external ALU between two requesters.
// It grants requests round-robin, latches the operands, holds them on the ALU for
// EXEC_CYCLES cycles and then captures the result. The response is held until the
// consumer takes it.
// Ports:
//   clk, rst    : clock and asynchronous active-high reset.
//   bus         : request and response handshakes (alu_arbiter_if.slave).
//   busy        : high whenever the FSM is not IDLE.
//   alu_in1/2   : registered ALU operands.
//   alu_opcode  : registered ALU opcode.
//   alu_out     : ALU result.
//   alu_error   : ALU overflow flag.
module alu_arbiter #(
  parameter int DATA_W      = 4,
  parameter int EXEC_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  alu_arbiter_if.slave      bus,
  output logic              busy,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [1:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_error
);

  localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic              rr_last_q, rr_last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              id_q, id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_id_q, rsp_id_d;

  logic              gnt_any;
  logic              gnt_id;
  logic              ready0, ready1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_last_q  <= 1'b1;
      cnt_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      rsp_id_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      id_q       <= id_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    id_d       = id_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    rsp_id_d   = rsp_id_q;
    gnt_any    = 1'b0;
    gnt_id     = 1'b0;
    ready0     = 1'b0;
    ready1     = 1'b0;

    case (state_q)
      IDLE: begin
        gnt_any = bus.req0_valid | bus.req1_valid;
        // A lone requester always wins. On a tie, the one not served last wins.
        if (bus.req0_valid && bus.req1_valid) gnt_id = ~rr_last_q;
        else                                  gnt_id = bus.req1_valid;
        ready0 = gnt_any & ~gnt_id;
        ready1 = gnt_any &  gnt_id;
        // ready is raised only toward a valid requester, so grant implies transfer.
        if (gnt_any) begin
          op_d      = gnt_id ? bus.req1_op : bus.req0_op;
          a_d       = gnt_id ? bus.req1_a  : bus.req0_a;
          b_d       = gnt_id ? bus.req1_b  : bus.req0_b;
          id_d      = gnt_id;
          rr_last_d = gnt_id;
          cnt_d     = CNT_LOAD;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          rsp_data_d = alu_out;
          rsp_err_d  = alu_error;
          rsp_id_d   = id_q;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ready is masked by rst so that every output reads 0 while reset is held.
  assign bus.req0_ready = ready0 & ~rst;
  assign bus.req1_ready = ready1 & ~rst;
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;
  assign busy           = (state_q != IDLE);
  assign alu_in1        = a_q;
  assign alu_in2        = b_q;
  assign alu_opcode     = op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  alu_arbiter_if #(.DATA_W(4)) bus1();
  alu_arbiter_if #(.DATA_W(4)) bus3();

  logic       busy1, busy3;
  logic [3:0] in1_1, in2_1, out_1, in1_3, in2_3, out_3;
  logic [1:0] opc1, opc3;
  logic       err1, err3;

  alu_arbiter #(.DATA_W(4), .EXEC_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .busy(busy1),
    .alu_in1(in1_1), .alu_in2(in2_1), .alu_opcode(opc1),
    .alu_out(out_1), .alu_error(err1)
  );

  alu_arbiter #(.DATA_W(4), .EXEC_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .busy(busy3),
    .alu_in1(in1_3), .alu_in2(in2_3), .alu_opcode(opc3),
    .alu_out(out_3), .alu_error(err3)
  );

  // Reference 4-bit ALU with two's-complement overflow on ADD/SUB.
  function automatic logic [4:0] alu_f(input logic [1:0] op, input logic [3:0] a,
                                       input logic [3:0] b);
    logic [3:0] r;
    logic       e;
    r = '0;
    e = 1'b0;
    case (op)
      2'd0: begin r = a + b; e = (a[3] == b[3]) && (r[3] != a[3]); end
      2'd1: begin r = a - b; e = (a[3] != b[3]) && (r[3] != a[3]); end
      2'd2: r = ~(a & b);
      default: r = a ^ b;
    endcase
    return {e, r};
  endfunction

  always_comb {err1, out_1} = alu_f(opc1, in1_1, in2_1);
  always_comb {err3, out_3} = alu_f(opc3, in1_3, in2_3);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus helper on bus1. It issues one request, waits for the grant and then
  // waits for rsp_valid. It returns what it observed; callers do the comparing.
  task automatic run_op(input logic id, input logic [1:0] op, input logic [3:0] a,
                        input logic [3:0] b, output int lat, output logic [3:0] data,
                        output logic err, output logic rid, output bit tmo);
    int n;
    tmo = 1'b0;
    if (!id) begin
      bus1.req0_op = op; bus1.req0_a = a; bus1.req0_b = b; bus1.req0_valid = 1'b1;
    end else begin
      bus1.req1_op = op; bus1.req1_a = a; bus1.req1_b = b; bus1.req1_valid = 1'b1;
    end
    n = 0;
    #1;
    while (!(id ? bus1.req1_ready : bus1.req0_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) tmo = 1'b1;
    @(negedge clk);
    bus1.req0_valid = 1'b0;
    bus1.req1_valid = 1'b0;
    lat = 1;
    while (!bus1.rsp_valid && lat < 20) begin
      @(negedge clk); lat++;
    end
    if (!bus1.rsp_valid) tmo = 1'b1;
    data = bus1.rsp_data;
    err  = bus1.rsp_err;
    rid  = bus1.rsp_id;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy1); end
    checks++; if (bus1.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", bus1.rsp_valid); end
    checks++; if ({in1_1, in2_1, opc1} !== 10'd0) begin errors++; $display("FAIL reset_alu_regs got=%h exp=0", {in1_1, in2_1, opc1}); end
    checks++; if ({bus1.rsp_data, bus1.rsp_err, bus1.rsp_id} !== 6'd0) begin errors++; $display("FAIL reset_rsp_regs got=%h exp=0", {bus1.rsp_data, bus1.rsp_err, bus1.rsp_id}); end
    bus1.req0_valid = 1'b1;
    #1;
    checks++; if (bus1.req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0 got=%b exp=0", bus1.req0_ready); end
    bus1.req0_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat; logic [3:0] d; logic e, rid; bit tmo;
    bus1.rsp_ready = 1'b1;
    run_op(1'b0, 2'd0, 4'd3, 4'd4, lat, d, e, rid, tmo);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL t1_timeout got=%b exp=0", tmo); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL t1_latency got=%0d exp=2", lat); end
    checks++; if ({rid, e, d} !== {1'b0, 1'b0, 4'd7}) begin errors++; $display("FAIL t1_rsp got id=%b err=%b data=%h exp id=0 err=0 data=7", rid, e, d); end
    @(negedge clk);
    checks++; if ({bus1.rsp_valid, busy1} !== 2'b00) begin errors++; $display("FAIL t1_back_to_idle got valid/busy=%b exp=00", {bus1.rsp_valid, busy1}); end
  endtask

  task automatic test_overflow;
    int lat; logic [3:0] d; logic e, rid; bit tmo;
    bus1.rsp_ready = 1'b1;
    run_op(1'b1, 2'd0, 4'd7, 4'd1, lat, d, e, rid, tmo);
    checks++; if ({tmo, rid, e, d} !== {1'b0, 1'b1, 1'b1, 4'd8}) begin errors++; $display("FAIL t2_add_ovf got tmo=%b id=%b err=%b data=%h exp 0 1 1 8", tmo, rid, e, d); end
    run_op(1'b1, 2'd1, 4'd8, 4'd1, lat, d, e, rid, tmo);
    checks++; if ({tmo, rid, e, d} !== {1'b0, 1'b1, 1'b1, 4'd7}) begin errors++; $display("FAIL t2_sub_ovf got tmo=%b id=%b err=%b data=%h exp 0 1 1 7", tmo, rid, e, d); end
    run_op(1'b1, 2'd2, 4'hF, 4'hF, lat, d, e, rid, tmo);
    checks++; if ({tmo, rid, e, d} !== {1'b0, 1'b1, 1'b0, 4'd0}) begin errors++; $display("FAIL t2_nand got tmo=%b id=%b err=%b data=%h exp 0 1 0 0", tmo, rid, e, d); end
  endtask

  task automatic test_alternation;
    logic g[6];
    int   gc[6];
    int   ngr, nrsp;
    bit   both;
    ngr = 0; nrsp = 0; both = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus1.rsp_ready = 1'b1;
    bus1.req0_op = 2'd0; bus1.req0_a = 4'd1; bus1.req0_b = 4'd1;
    bus1.req1_op = 2'd3; bus1.req1_a = 4'd5; bus1.req1_b = 4'd3;
    bus1.req0_valid = 1'b1; bus1.req1_valid = 1'b1;
    for (int cyc = 0; cyc < 60 && nrsp < 6; cyc++) begin
      #1;
      if (ngr == 6) begin bus1.req0_valid = 1'b0; bus1.req1_valid = 1'b0; #1; end
      if (bus1.req0_ready && bus1.req1_ready) both = 1'b1;
      if ((bus1.req0_ready || bus1.req1_ready) && ngr < 6) begin
        g[ngr] = bus1.req1_ready; gc[ngr] = cyc; ngr++;
      end
      if (bus1.rsp_valid && nrsp < 6) begin
        checks++; if (bus1.rsp_id !== nrsp[0]) begin errors++; $display("FAIL t3_rsp_id[%0d] got=%b exp=%b", nrsp, bus1.rsp_id, nrsp[0]); end
        checks++; if (bus1.rsp_data !== (nrsp[0] ? 4'd6 : 4'd2)) begin errors++; $display("FAIL t3_rsp_data[%0d] got=%h exp=%h", nrsp, bus1.rsp_data, nrsp[0] ? 4'd6 : 4'd2); end
        nrsp++;
      end
      @(negedge clk);
    end
    bus1.req0_valid = 1'b0; bus1.req1_valid = 1'b0;
    checks++; if (ngr !== 6 || nrsp !== 6) begin errors++; $display("FAIL t3_counts got grants=%0d rsps=%0d exp 6 6", ngr, nrsp); end
    checks++; if (both !== 1'b0) begin errors++; $display("FAIL t3_both_ready got=%b exp=0", both); end
    for (int i = 0; i < ngr; i++) begin
      checks++; if (g[i] !== i[0]) begin errors++; $display("FAIL t3_grant[%0d] got=%b exp=%b", i, g[i], i[0]); end
      if (i > 0) begin
        checks++; if (gc[i] - gc[i-1] !== 3) begin errors++; $display("FAIL t3_spacing[%0d] got=%0d exp=3", i, gc[i] - gc[i-1]); end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int lat; logic [3:0] d; logic e, rid; bit tmo;
    bus1.rsp_ready = 1'b0;
    run_op(1'b0, 2'd2, 4'd6, 4'd3, lat, d, e, rid, tmo);
    checks++; if ({tmo, rid, d} !== {1'b0, 1'b0, 4'hD}) begin errors++; $display("FAIL t4_rsp got tmo=%b id=%b data=%h exp 0 0 d", tmo, rid, d); end
    bus1.req1_op = 2'd0; bus1.req1_a = 4'd1; bus1.req1_b = 4'd2; bus1.req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({bus1.rsp_valid, bus1.rsp_id, bus1.rsp_data, bus1.req0_ready, bus1.req1_ready} !== {1'b1, 1'b0, 4'hD, 2'b00}) begin
        errors++;
        $display("FAIL t4_hold[%0d] got valid=%b id=%b data=%h rdy=%b%b exp 1 0 d 00", i,
                 bus1.rsp_valid, bus1.rsp_id, bus1.rsp_data, bus1.req0_ready, bus1.req1_ready);
      end
    end
    bus1.req1_valid = 1'b0;
    bus1.rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if ({bus1.rsp_valid, busy1, bus1.rsp_data} !== {2'b00, 4'hD}) begin errors++; $display("FAIL t4_release got valid=%b busy=%b data=%h exp 0 0 d", bus1.rsp_valid, busy1, bus1.rsp_data); end
  endtask

  task automatic test_async_reset;
    int lat; logic [3:0] d; logic e, rid; bit tmo; int n; bit seen;
    bus1.rsp_ready = 1'b1;
    bus1.req0_op = 2'd0; bus1.req0_a = 4'd2; bus1.req0_b = 4'd2; bus1.req0_valid = 1'b1;
    n = 0;
    #1;
    while (!bus1.req0_ready && n < 20) begin @(negedge clk); #1; n++; end
    checks++; if (n >= 20) begin errors++; $display("FAIL t5_grant_timeout got=%0d cycles exp<20", n); end
    @(posedge clk);
    #2;
    checks++; if ({busy1, in1_1} !== {1'b1, 4'd2}) begin errors++; $display("FAIL t5_in_exec got busy=%b in1=%h exp 1 2", busy1, in1_1); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({busy1, bus1.rsp_valid, in1_1, in2_1, opc1, bus1.req0_ready} !== 13'd0) begin
      errors++;
      $display("FAIL t5_async got busy=%b valid=%b in1=%h in2=%h opc=%h rdy0=%b exp all 0",
               busy1, bus1.rsp_valid, in1_1, in2_1, opc1, bus1.req0_ready);
    end
    bus1.req0_valid = 1'b0;
    #3 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus1.rsp_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL t5_no_rsp got rsp_valid seen=%b exp=0", seen); end
    run_op(1'b1, 2'd0, 4'd1, 4'd1, lat, d, e, rid, tmo);
    checks++; if ({tmo, rid, d} !== {1'b0, 1'b1, 4'd2}) begin errors++; $display("FAIL t5_post_req1 got tmo=%b id=%b data=%h exp 0 1 2", tmo, rid, d); end
    @(negedge clk);
  endtask

  task automatic test_exec3;
    int n;
    bus3.rsp_ready = 1'b1;
    bus3.req0_op = 2'd1; bus3.req0_a = 4'd2; bus3.req0_b = 4'd5; bus3.req0_valid = 1'b1;
    n = 0;
    #1;
    while (!bus3.req0_ready && n < 20) begin @(negedge clk); #1; n++; end
    checks++; if (n >= 20) begin errors++; $display("FAIL t6_grant_timeout got=%0d cycles exp<20", n); end
    @(negedge clk);
    bus3.req0_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if ({in1_3, in2_3, opc3, bus3.rsp_valid} !== {4'd2, 4'd5, 2'd1, 1'b0}) begin
        errors++;
        $display("FAIL t6_hold[T+%0d] got in1=%h in2=%h opc=%h valid=%b exp 2 5 1 0", i + 1,
                 in1_3, in2_3, opc3, bus3.rsp_valid);
      end
    end
    @(negedge clk);
    checks++;
    if ({bus3.rsp_valid, bus3.rsp_id, bus3.rsp_data, bus3.rsp_err} !== {1'b1, 1'b0, 4'hD, 1'b0}) begin
      errors++;
      $display("FAIL t6_rsp got valid=%b id=%b data=%h err=%b exp 1 0 d 0",
               bus3.rsp_valid, bus3.rsp_id, bus3.rsp_data, bus3.rsp_err);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus1.req0_valid = 1'b0; bus1.req0_op = '0; bus1.req0_a = '0; bus1.req0_b = '0;
    bus1.req1_valid = 1'b0; bus1.req1_op = '0; bus1.req1_a = '0; bus1.req1_b = '0;
    bus1.rsp_ready  = 1'b0;
    bus3.req0_valid = 1'b0; bus3.req0_op = '0; bus3.req0_a = '0; bus3.req0_b = '0;
    bus3.req1_valid = 1'b0; bus3.req1_op = '0; bus3.req1_a = '0; bus3.req1_b = '0;
    bus3.rsp_ready  = 1'b0;
    @(negedge clk);
    test_reset;
    test_basic;
    test_overflow;
    test_alternation;
    test_backpressure;
    test_async_reset;
    test_exec3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
